// File: rtl/video_pattern_gen_if.sv
// rtl/video_pattern_gen_if.sv - control and parallel video bundle for video_pattern_gen
//
// Signals:
//   enable       1   1 = run raster, 0 = hold idle
//   pattern_sel  2   0 black, 1 colour bars, 2 ramp, 3 checker
//   vid_de       1   data enable
//   vid_hsync    1   horizontal sync
//   vid_vsync    1   vertical sync
//   vid_d        36  pixel data {R[11:0], G[11:0], B[11:0]}
//   frame_start  1   pulse with the first active pixel of each frame
// master: the generator; slave: the video consumer that also owns the controls.
interface video_pattern_gen_if;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        vid_de;
    logic        vid_hsync;
    logic        vid_vsync;
    logic [35:0] vid_d;
    logic        frame_start;

    modport master (
        input  enable, pattern_sel,
        output vid_de, vid_hsync, vid_vsync, vid_d, frame_start
    );

    modport slave (
        output enable, pattern_sel,
        input  vid_de, vid_hsync, vid_vsync, vid_d, frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - CEA-style raster and 36-bit test pattern source for the SII9136 TX
//
// Ports:
//   clk     in   pixel clock (also forwarded as the TX input clock)
//   reset_  in   asynchronous active-low reset
//   vid     master modport of video_pattern_gen_if (enable/pattern_sel in, raster and pixel data out)
// All outputs are registered, one cycle behind the h/v counters.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                clk,
    input  logic                reset_,
    video_pattern_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit bounds so an end position equal to 4096 still compares correctly.
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]  pat_q, pat_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [35:0] d_q, d_d;
    logic        fs_q, fs_d;

    logic [12:0] h13, v13;
    logic        frame_origin;
    logic        h_wrap, v_wrap;
    logic [2:0]  bar;
    logic [2:0]  bar_rgb;

    assign h13          = {1'b0, h_q};
    assign v13          = {1'b0, v_q};
    assign frame_origin = (h_q == 12'd0) && (v_q == 12'd0);
    assign h_wrap       = (h_q == H_LAST);
    assign v_wrap       = (v_q == V_LAST);

    // Bar index = floor(h*8/H_ACTIVE): count how many constant boundaries h*8 has reached.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({3'b000, h_q, 3'b000} >= 18'(k * H_ACTIVE)) begin
                bar = 3'(k);
            end
        end
    end

    // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        case (bar)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    always_comb begin
        h_d         = h_wrap ? 12'd0 : h_q + 12'd1;
        v_d         = v_q;
        frame_cnt_d = frame_cnt_q;
        if (h_wrap) begin
            v_d = v_wrap ? 12'd0 : v_q + 12'd1;
            if (v_wrap) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        // The pattern is latched at the frame origin and used for that whole frame.
        pat_d = frame_origin ? vid.pattern_sel : pat_q;

        de_d = (h13 < H_ACT) && (v13 < V_ACT);
        fs_d = de_d && frame_origin;

        hs_d = ((h13 >= HS_START) && (h13 < HS_END)) ? HS_POL : ~HS_POL;

        // vsync edges land on the hsync leading edge of the first and last vsync lines.
        vs_d = ~VS_POL;
        if (((v13 == VS_START) && (h13 >= HS_START)) ||
            ((v13 >  VS_START) && (v13 < VS_END))   ||
            ((v13 == VS_END)   && (h13 <  HS_START))) begin
            vs_d = VS_POL;
        end

        d_d = 36'd0;
        if (de_d) begin
            case (pat_d)
                2'd1:    d_d = {{12{bar_rgb[2]}}, {12{bar_rgb[1]}}, {12{bar_rgb[0]}}};
                2'd2:    d_d = {h_q, h_q, h_q};
                2'd3:    d_d = (h_q[4] ^ v_q[4] ^ frame_cnt_q[0]) ? {36{1'b1}} : 36'd0;
                default: d_d = 36'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            h_q         <= 12'd0;
            v_q         <= 12'd0;
            frame_cnt_q <= 16'd0;
            pat_q       <= 2'd0;
            de_q        <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            d_q         <= 36'd0;
            fs_q        <= 1'b0;
        end else if (!vid.enable) begin
            // Idle: clearing the counters makes the next enable start a fresh frame.
            h_q         <= 12'd0;
            v_q         <= 12'd0;
            frame_cnt_q <= 16'd0;
            de_q        <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            d_q         <= 36'd0;
            fs_q        <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            d_q         <= d_d;
            fs_q        <= fs_d;
        end
    end

    assign vid.vid_de      = de_q;
    assign vid.vid_hsync   = hs_q;
    assign vid.vid_vsync   = vs_q;
    assign vid.vid_d       = d_q;
    assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - scoreboard bench for video_pattern_gen on a small raster
module tb_video_pattern_gen;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 4,  VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = 24, VT = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_pattern_gen_if vif ();

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk    (clk),
        .reset_ (rst_n),
        .vid    (vif.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [35:0] bar_tab [8];
    initial begin
        bar_tab[0] = 36'hFFF_FFF_FFF;
        bar_tab[1] = 36'hFFF_FFF_000;
        bar_tab[2] = 36'h000_FFF_FFF;
        bar_tab[3] = 36'h000_FFF_000;
        bar_tab[4] = 36'hFFF_000_FFF;
        bar_tab[5] = 36'hFFF_000_000;
        bar_tab[6] = 36'h000_000_FFF;
        bar_tab[7] = 36'h000_000_000;
    end

    // Reference model state: counter values presented to the next clock edge.
    int mh = 0, mv = 0, mf = 0, mpat = 0;
    logic [39:0] sb_q [$];
    int cyc = 0;
    int last_fs = -1;
    int de_cnt = 0;
    int vs_len = 0;

    function automatic logic [39:0] observe();
        return {vif.frame_start, vif.vid_de, vif.vid_hsync, vif.vid_vsync, vif.vid_d};
    endfunction

    task automatic step();
        logic [39:0] exp, obs;
        logic        de, hs, vs, fs, running;
        logic [35:0] d;
        logic [11:0] x;
        int          pat, pos;
        running = rst_n && vif.enable;
        if (!running) begin
            exp  = 40'd0;
            mh = 0; mv = 0; mf = 0;
            if (!rst_n) mpat = 0;
        end else begin
            pat = (mh == 0 && mv == 0) ? int'(vif.pattern_sel) : mpat;
            de  = (mh < HA) && (mv < VA);
            fs  = de && mh == 0 && mv == 0;
            hs  = (mh >= HA + HFP) && (mh < HA + HFP + HSW);
            pos = mv * HT + mh;
            vs  = (pos >= (VA + VFP) * HT + HA + HFP) && (pos < (VA + VFP + VSW) * HT + HA + HFP);
            x   = 12'(mh);
            d   = 36'd0;
            if (de) begin
                case (pat)
                    1: d = bar_tab[(mh * 8) / HA];
                    2: d = {x, x, x};
                    3: d = (((mh >> 4) ^ (mv >> 4) ^ mf) & 1) != 0 ? 36'hFFF_FFF_FFF : 36'd0;
                    default: d = 36'd0;
                endcase
            end
            exp  = {fs, de, hs, vs, d};
            mpat = pat;
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin
                    mv = 0;
                    mf = mf + 1;
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        cyc++;
        obs = observe();
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            check_eq("pix", {24'd0, obs}, {24'd0, sb_q.pop_front()});
        end
        if (!running) begin
            last_fs = -1;
            de_cnt  = 0;
            vs_len  = 0;
        end else begin
            if (obs[39]) begin
                if (last_fs >= 0) begin
                    check_eq("fs_period", cyc - last_fs, 168);
                    check_eq("de_per_frame", de_cnt, 64);
                end
                last_fs = cyc;
                de_cnt  = 0;
            end
            if (obs[38]) de_cnt++;
            if (obs[36]) begin
                vs_len++;
            end else if (vs_len > 0) begin
                check_eq("vs_len", vs_len, 24);
                vs_len = 0;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        int g;
        g = 0;
        while (!(mh == h && mv == v) && g < 400) begin
            step();
            g++;
        end
        if (g >= 400) check_eq("run_to_timeout", g, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        vif.enable      = 1'b1;
        vif.pattern_sel = 2'd1;
        repeat (3) step();
        check_eq("rst_idle", observe(), 40'd0);

        rst_n = 1'b1;
        step();
        check_eq("first_de_fs", {vif.frame_start, vif.vid_de}, 2'b11);
        repeat (2 * 168 - 1) step();

        // Switch to ramp mid-frame; bars must persist until the frame ends.
        run_to(5, 2);
        vif.pattern_sel = 2'd2;
        repeat (2 * 168) step();

        // Checker, then drop enable at h=7 of line 2.
        vif.pattern_sel = 2'd3;
        repeat (168) step();
        run_to(7, 2);
        vif.enable = 1'b0;
        step();
        check_eq("en_drop_idle", observe(), 40'd0);
        repeat (4) step();
        vif.enable = 1'b1;
        step();
        check_eq("reen_fs", vif.frame_start, 1'b1);
        repeat (2 * 168) step();

        // Asynchronous reset mid-line while bars are showing.
        vif.pattern_sel = 2'd1;
        repeat (200) step();
        run_to(4, 1);
        check_eq("pre_rst_d", vif.vid_d, 36'hFFF_FFF_000);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", observe(), 40'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (170) step();

        check_eq("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
